sam_cpu_clk_sched: RTL and testbench
====================================

# sam_cpu_clk_sched

Single-clock scheduler that derives the 6809 E/Q quadrature clocks from the SAM master clock and divides each E cycle between video and CPU memory slots. It applies the SAM rate bits (slow, address-dependent, fast) only at cycle boundaries, so rate changes never produce a runt E or Q phase. It sits between the SAM control-register file and the DRAM address/RAS/CAS sequencer, which consume its slot strobes.

## Interface
- `AD_LO`, default 16'h8000: lowest address that runs fast in address-dependent mode.
- `AD_HI`, default 16'hFEFF: highest address that runs fast in address-dependent mode.
- `clk`  in  1  master clock; every register in the block uses its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rate`  in  2  SAM R1:R0: 00 slow, 01 address-dependent, 10 fast, 11 fast (see Configuration).
- `addr`  in  16  CPU address bus, already synchronous to `clk`.
- `e`  out  1  6809 E clock.
- `q`  out  1  6809 Q clock, leading E by one quarter.
- `phase`  out  2  current quarter of the E cycle, 0..3.
- `fast_cyc`  out  1  current E cycle runs at a fast or turbo length.
- `vid_slot`  out  1  one-`clk` strobe marking the start of the video slot.
- `cpu_slot`  out  1  one-`clk` strobe marking the start of the CPU slot (E rise).

## Operation
- 4-bit cycle counter `cnt` counts 0..LEN-1 and then wraps to 0.
  - LEN = 16 for slow, 8 for fast, 4 for turbo.
  - Quarter length QL = LEN/4.
- `phase` = `cnt` / QL. Outputs per phase:
  - phase 0: E=0, Q=0.
  - phase 1: E=0, Q=1.
  - phase 2: E=1, Q=1.
  - phase 3: E=1, Q=0.
- Cycle length for the next cycle is decided on the `clk` where `cnt` = LEN-1, using `rate` and `addr` sampled on that edge:
  - 00: slow.
  - 01: fast if AD_LO ≤ `addr` ≤ AD_HI, otherwise slow.
  - 10: fast.
  - 11: fast, or turbo when turbo is compiled in.
- The decision is latched into a registered length select. It is held constant for the whole cycle; mid-cycle changes to `rate` or `addr` have no effect.
- `vid_slot` = 1 for the `clk` where `cnt` = 0, only when the current cycle is slow. Fast and turbo cycles steal the video slot, matching SAM behaviour.
- `cpu_slot` = 1 for the `clk` where `cnt` = 2·QL, in every cycle.
- `fast_cyc` = 1 whenever the current cycle's LEN < 16.

## Timing
- All outputs are registered. They update on the same edge as `cnt` and are decoded from the new `cnt` value, so they are never one cycle stale.
- Reset values: `cnt`=0, slow length selected, `e`=0, `q`=0, `phase`=0, `fast_cyc`=0, `vid_slot`=0, `cpu_slot`=0.
- First cycle after reset:
  - It is always slow.
  - `vid_slot` first pulses on the first `clk` after `rst` deasserts.
- `rst` asserted mid-cycle: on the next edge every output returns to its reset value. No partial E high is completed.
- Latency from a `rate` change to its effect: at most one full E cycle. The change applies from the first boundary whose last-count edge sees the new value.
- E high time is exactly LEN/2 `clk`. Q leads E by exactly QL `clk`.
- Switching between lengths changes only the length of the following cycle. There is no E/Q glitch at any boundary.
- `vid_slot` and `cpu_slot` are never high on the same `clk`.

## Configuration
- `SAM_TURBO_EN` defined:
  - `rate`=11 selects turbo: LEN=4, QL=1.
  - `fast_cyc`=1 in turbo.
  - `vid_slot` is suppressed in turbo.
- `SAM_TURBO_EN` undefined: `rate`=11 behaves exactly as 10, and no LEN=4 logic is synthesised.

## Structure
- Shared package `sam_pkg` holds:
  - the rate encodings (RATE_SLOW, RATE_AD, RATE_FAST, RATE_TURBO);
  - the cycle-length constants LEN_SLOW=16, LEN_FAST=8, LEN_TURBO=4;
  - the default AD window bounds.
- One sub-module, `sam_rate_sel`: combinational decision of the next cycle length from `rate`, `addr` and the AD bounds. It is kept separate so it can be reused by the refresh scheduler.
- The counter, E/Q decode and slot strobes stay in the top module.

## Test plan
- Reset, then `rate`=00 for 48 `clk`:
  - E period is 16 `clk`; E rises at `cnt`=8 and Q rises at `cnt`=4.
  - `vid_slot` pulses at `clk` 0, 16 and 32; `cpu_slot` pulses at 8, 24 and 40.
- `rate`=10 set at `cnt`=5 of a slow cycle:
  - The current cycle completes as 16 `clk`.
  - The next cycles are 8 `clk` with `fast_cyc`=1 and no `vid_slot`.
- `rate`=01:
  - `addr`=16'hA000 at the last count gives an 8-`clk` cycle.
  - `addr`=16'hFF20 gives a 16-`clk` cycle.
  - `addr`=16'h7FFF gives a 16-`clk` cycle.
- `rst` pulsed at `cnt`=10 of a slow cycle: on the next edge `e`=0, `q`=0, `phase`=0, and a new slow cycle starts.
- `rate`=11 with `SAM_TURBO_EN` defined: E period is 4 `clk`, each phase lasts 1 `clk`, and `vid_slot` stays 0.
- `rate`=11 with `SAM_TURBO_EN` undefined: E period is 8 `clk`.
- Random toggling of `rate` and `addr` for 10k `clk`: check that every E high time equals LEN/2 and that Q leads E by exactly QL.

Source files
------------

// File: rtl/sam_pkg.sv
// Shared definitions for the SAM CPU clock scheduler: rate encodings, cycle lengths,
// address-dependent window defaults and length-select decode helpers.
package sam_pkg;

    localparam logic [1:0] RATE_SLOW  = 2'b00;
    localparam logic [1:0] RATE_AD    = 2'b01;
    localparam logic [1:0] RATE_FAST  = 2'b10;
    localparam logic [1:0] RATE_TURBO = 2'b11;

    localparam int unsigned LEN_SLOW  = 16;
    localparam int unsigned LEN_FAST  = 8;
    localparam int unsigned LEN_TURBO = 4;

    localparam logic [15:0] AD_LO_DEFAULT = 16'h8000;
    localparam logic [15:0] AD_HI_DEFAULT = 16'hFEFF;

    typedef enum logic [1:0] {
        LSEL_SLOW  = 2'd0,
        LSEL_FAST  = 2'd1,
        LSEL_TURBO = 2'd2
    } len_sel_e;

    // Terminal count of a cycle, i.e. LEN-1.
    function automatic logic [3:0] last_cnt(input len_sel_e sel);
        case (sel)
            LSEL_FAST:  return 4'(LEN_FAST - 1);
`ifdef SAM_TURBO_EN
            LSEL_TURBO: return 4'(LEN_TURBO - 1);
`endif
            default:    return 4'(LEN_SLOW - 1);
        endcase
    endfunction

    // Count at which E rises (2*QL).
    function automatic logic [3:0] mid_cnt(input len_sel_e sel);
        case (sel)
            LSEL_FAST:  return 4'(LEN_FAST / 2);
`ifdef SAM_TURBO_EN
            LSEL_TURBO: return 4'(LEN_TURBO / 2);
`endif
            default:    return 4'(LEN_SLOW / 2);
        endcase
    endfunction

    // cnt / QL; QL is a power of two so the quarter is a plain bit slice.
    function automatic logic [1:0] phase_of(input logic [3:0] cnt, input len_sel_e sel);
        case (sel)
            LSEL_FAST:  return cnt[2:1];
`ifdef SAM_TURBO_EN
            LSEL_TURBO: return cnt[1:0];
`endif
            default:    return cnt[3:2];
        endcase
    endfunction

endpackage

// File: rtl/sam_rate_sel.sv
// Combinational next-cycle length decision from the SAM rate bits and CPU address.
// Turbo length for rate 11 exists only when SAM_TURBO_EN is defined.
module sam_rate_sel
    import sam_pkg::*;
#(
    parameter logic [15:0] AD_LO = AD_LO_DEFAULT,
    parameter logic [15:0] AD_HI = AD_HI_DEFAULT
) (
    input  logic [1:0]  i_rate,
    input  logic [15:0] i_addr,
    output len_sel_e    o_len_sel
);

    logic w_in_window;

    assign w_in_window = (i_addr >= AD_LO) && (i_addr <= AD_HI);

    always_comb begin
        o_len_sel = LSEL_SLOW;
        case (i_rate)
            RATE_SLOW:  o_len_sel = LSEL_SLOW;
            RATE_AD:    o_len_sel = w_in_window ? LSEL_FAST : LSEL_SLOW;
            RATE_FAST:  o_len_sel = LSEL_FAST;
`ifdef SAM_TURBO_EN
            RATE_TURBO: o_len_sel = LSEL_TURBO;
`else
            RATE_TURBO: o_len_sel = LSEL_FAST;
`endif
            default:    o_len_sel = LSEL_SLOW;
        endcase
    end

endmodule

// File: rtl/sam_cpu_clk_sched.sv
// SAM E/Q clock and video/CPU slot scheduler. Cycle length is chosen only at the
// terminal count, so E/Q never glitch. Optional turbo (LEN=4) via SAM_TURBO_EN.
module sam_cpu_clk_sched
    import sam_pkg::*;
#(
    parameter logic [15:0] AD_LO = AD_LO_DEFAULT,
    parameter logic [15:0] AD_HI = AD_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rate,
    input  logic [15:0] addr,
    output logic        e,
    output logic        q,
    output logic [1:0]  phase,
    output logic        fast_cyc,
    output logic        vid_slot,
    output logic        cpu_slot
);

    logic       r_run;
    logic [3:0] r_cnt;
    len_sel_e   r_len;
    logic       r_e;
    logic       r_q;
    logic [1:0] r_phase;
    logic       r_fast_cyc;
    logic       r_vid_slot;
    logic       r_cpu_slot;

    len_sel_e   w_dec_len;
    logic [3:0] w_cnt_nxt;
    len_sel_e   w_len_nxt;
    logic [1:0] w_phase_nxt;

    sam_rate_sel #(
        .AD_LO (AD_LO),
        .AD_HI (AD_HI)
    ) u_rate_sel (
        .i_rate    (rate),
        .i_addr    (addr),
        .o_len_sel (w_dec_len)
    );

    // r_run is low only in the reset state; the first edge after reset opens a slow cycle at cnt 0.
    always_comb begin
        w_cnt_nxt = r_cnt + 4'd1;
        w_len_nxt = r_len;
        if (!r_run) begin
            w_cnt_nxt = 4'd0;
            w_len_nxt = LSEL_SLOW;
        end else if (r_cnt == last_cnt(r_len)) begin
            w_cnt_nxt = 4'd0;
            w_len_nxt = w_dec_len;
        end
        w_phase_nxt = phase_of(w_cnt_nxt, w_len_nxt);
    end

    // Outputs are decoded from the next count so they line up with cnt on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_cnt      <= 4'd0;
            r_len      <= LSEL_SLOW;
            r_e        <= 1'b0;
            r_q        <= 1'b0;
            r_phase    <= 2'd0;
            r_fast_cyc <= 1'b0;
            r_vid_slot <= 1'b0;
            r_cpu_slot <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_phase    <= w_phase_nxt;
            r_e        <= w_phase_nxt[1];
            r_q        <= w_phase_nxt[1] ^ w_phase_nxt[0];
            r_fast_cyc <= (w_len_nxt != LSEL_SLOW);
            r_vid_slot <= (w_cnt_nxt == 4'd0) && (w_len_nxt == LSEL_SLOW);
            r_cpu_slot <= (w_cnt_nxt == mid_cnt(w_len_nxt));
        end
    end

    assign e        = r_e;
    assign q        = r_q;
    assign phase    = r_phase;
    assign fast_cyc = r_fast_cyc;
    assign vid_slot = r_vid_slot;
    assign cpu_slot = r_cpu_slot;

endmodule

// File: tb/tb_sam_cpu_clk_sched.sv
// Self-checking bench for sam_cpu_clk_sched: cycle-level reference model plus
// directed scenarios and randomized rate/address toggling.
module tb_sam_cpu_clk_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rate;
    logic [15:0] addr;
    logic        e, q, fast_cyc, vid_slot, cpu_slot;
    logic [1:0]  phase;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sam_cpu_clk_sched dut (
        .clk      (clk),
        .rst      (rst),
        .rate     (rate),
        .addr     (addr),
        .e        (e),
        .q        (q),
        .phase    (phase),
        .fast_cyc (fast_cyc),
        .vid_slot (vid_slot),
        .cpu_slot (cpu_slot)
    );

    // Reference model: position k within a cycle of length m_len.
    bit m_run = 1'b0;
    int m_k   = 0;
    int m_len = 16;

    int tcyc = 0;
    int n_erise = 0, n_vid = 0, n_cpu = 0;
    bit q_seen = 0, e_hi = 0, prev_rise_v = 0;
    int t_qrise = 0, t_erise = 0, t_prev_rise = 0, len_prev_rise = 16;
    logic prev_e = 1'b0, prev_q = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int decide_len(input logic [1:0] r, input logic [15:0] a);
        case (r)
            2'b00: return 16;
            2'b01: return (a >= 16'h8000 && a <= 16'hFEFF) ? 8 : 16;
            2'b10: return 8;
`ifdef SAM_TURBO_EN
            default: return 4;
`else
            default: return 8;
`endif
        endcase
    endfunction

    task automatic step(input logic r, input logic [1:0] rt, input logic [15:0] ad);
        int ql, qtr;
        @(negedge clk);
        rst = r; rate = rt; addr = ad;
        @(posedge clk);
        if (r) begin
            m_run = 0; m_k = 0; m_len = 16;
        end else if (!m_run) begin
            m_run = 1; m_k = 0; m_len = 16;
        end else if (m_k == m_len - 1) begin
            m_k = 0; m_len = decide_len(rt, ad);
        end else begin
            m_k++;
        end
        tcyc++;
        #1;
        ql  = m_len / 4;
        qtr = m_k / ql;
        check_eq("e",        e,        (m_run && qtr >= 2) ? 1 : 0);
        check_eq("q",        q,        (m_run && (qtr == 1 || qtr == 2)) ? 1 : 0);
        check_eq("phase",    phase,    m_run ? qtr : 0);
        check_eq("fast_cyc", fast_cyc, (m_run && m_len < 16) ? 1 : 0);
        check_eq("vid_slot", vid_slot, (m_run && m_k == 0 && m_len == 16) ? 1 : 0);
        check_eq("cpu_slot", cpu_slot, (m_run && m_k == m_len / 2) ? 1 : 0);
        check_eq("slot_excl", vid_slot & cpu_slot, 0);
        if (vid_slot) n_vid++;
        if (cpu_slot) n_cpu++;
        if (r) begin
            q_seen = 0; e_hi = 0; prev_rise_v = 0;
        end else begin
            if (q && !prev_q) begin
                t_qrise = tcyc; q_seen = 1;
            end
            if (e && !prev_e) begin
                n_erise++;
                if (q_seen) check_eq("q_lead", tcyc - t_qrise, m_len / 4);
                if (prev_rise_v) check_eq("e_period", tcyc - t_prev_rise, len_prev_rise / 2 + m_len / 2);
                prev_rise_v = 1; t_prev_rise = tcyc; len_prev_rise = m_len;
                e_hi = 1; t_erise = tcyc;
            end
            if (!e && prev_e && e_hi) begin
                check_eq("e_high", tcyc - t_erise, len_prev_rise / 2);
                e_hi = 0;
            end
        end
        prev_e = e; prev_q = q;
    endtask

    task automatic ad_case(input string tag, input logic [15:0] ad, input logic exp_fast);
        int g = 0;
        while (m_k != m_len - 1 && g < 64) begin
            step(1'b0, 2'b01, 16'h0000);
            g++;
        end
        step(1'b0, 2'b01, ad);
        check_eq(tag, fast_cyc, exp_fast);
    endtask

    initial begin
        int g, base_e, base_v, base_c;
        logic [1:0]  cur_rate;
        logic [15:0] cur_addr;
        logic [15:0] pick [6];
        rst = 1'b1; rate = 2'b00; addr = 16'h0000;

        repeat (3) step(1'b1, 2'b00, 16'h0000);

        // Slow operation for 48 clk from reset release.
        base_e = n_erise; base_v = n_vid; base_c = n_cpu;
        repeat (48) step(1'b0, 2'b00, 16'h0000);
        check_eq("slow_e_rises", n_erise - base_e, 3);
        check_eq("slow_vid_cnt", n_vid - base_v, 3);
        check_eq("slow_cpu_cnt", n_cpu - base_c, 3);

        // Switch to fast while cnt=5 of a slow cycle.
        g = 0;
        while (m_k != 4 && g < 64) begin step(1'b0, 2'b00, 16'h0000); g++; end
        base_v = n_vid;
        repeat (40) step(1'b0, 2'b10, 16'h0000);
        check_eq("fast_vid_once", n_vid - base_v, 0);
        check_eq("fast_flag", fast_cyc, 1);

        // Address-dependent window.
        ad_case("ad_a000", 16'hA000, 1'b1);
        ad_case("ad_ff20", 16'hFF20, 1'b0);
        ad_case("ad_7fff", 16'h7FFF, 1'b0);
        ad_case("ad_8000", 16'h8000, 1'b1);
        ad_case("ad_feff", 16'hFEFF, 1'b1);
        ad_case("ad_ff00", 16'hFF00, 1'b0);

        // Reset at cnt=10 of a slow cycle.
        g = 0;
        while (!(m_len == 16 && m_k == 10) && g < 80) begin step(1'b0, 2'b00, 16'h0000); g++; end
        check_eq("pre_rst_e", e, 1);
        step(1'b1, 2'b00, 16'h0000);
        check_eq("rst_e", e, 0);
        check_eq("rst_q", q, 0);
        check_eq("rst_phase", phase, 0);
        step(1'b0, 2'b00, 16'h0000);
        check_eq("rst_restart_vid", vid_slot, 1);

        // Rate 11.
        repeat (24) step(1'b0, 2'b11, 16'h0000);
        base_e = n_erise; base_v = n_vid;
        repeat (32) step(1'b0, 2'b11, 16'h0000);
`ifdef SAM_TURBO_EN
        check_eq("r11_e_rises", n_erise - base_e, 8);
`else
        check_eq("r11_e_rises", n_erise - base_e, 4);
`endif
        check_eq("r11_no_vid", n_vid - base_v, 0);

        // Random rate/address toggling.
        pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'hFEFF;
        pick[3] = 16'hFF00; pick[4] = 16'hA000; pick[5] = 16'h1234;
        cur_rate = 2'b00; cur_addr = 16'h0000;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) cur_rate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                cur_addr = pick[$urandom_range(0, 5)];
            else
                cur_addr = 16'($urandom);
            step(($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0, cur_rate, cur_addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
